// File: rtl/keypad_pkg.sv
// rtl/keypad_pkg.sv - shared types and constants for the keypad front end
// Purpose: FSM state type, key code constants, no-key row pattern and
// active-low one-hot helpers used by keypad_decode and keypad_debounce.
// Ports: none (package).
package keypad_pkg;

  typedef enum logic [1:0] {
    IDLE,
    PRESS_WAIT,
    HELD,
    RELEASE_WAIT
  } kd_state_t;

  localparam logic [3:0] KEY_A    = 4'd10;
  localparam logic [3:0] KEY_B    = 4'd11;
  localparam logic [3:0] KEY_C    = 4'd12;
  localparam logic [3:0] KEY_D    = 4'd13;
  localparam logic [3:0] KEY_STAR = 4'd14;
  localparam logic [3:0] KEY_HASH = 4'd15;

  // Row sense pattern when no key is pressed on the driven column.
  localparam logic [3:0] ROWS_NONE = 4'b1111;

  // True when exactly one bit of an active-low vector is low.
  function automatic logic is_one_cold(input logic [3:0] v);
    logic ok;
    case (v)
      4'b0111, 4'b1011, 4'b1101, 4'b1110: ok = 1'b1;
      default:                            ok = 1'b0;
    endcase
    return ok;
  endfunction

  // Position of the low bit counted from the MSB (bit 3 -> 0).
  // Only meaningful when is_one_cold() holds.
  function automatic logic [1:0] cold_index(input logic [3:0] v);
    logic [1:0] idx;
    case (v)
      4'b0111: idx = 2'd0;
      4'b1011: idx = 2'd1;
      4'b1101: idx = 2'd2;
      default: idx = 2'd3;
    endcase
    return idx;
  endfunction

endpackage

// File: rtl/keypad_decode.sv
// rtl/keypad_decode.sv - combinational single-key decode of column drive and row sense
// Purpose: map one active-low column and one active-low row to a 4-bit key code.
// Ports:
//   kpc      in  [3:0] column drive, active-low one-hot, kpc[3] = column 0
//   kpr      in  [3:0] row sense, active-low, kpr[3] = row 0 (top)
//   raw_ok   out       exactly one column driven and exactly one row low
//   raw_code out [3:0] key code (digits 0-9, A-D 10-13, * 14, # 15)
module keypad_decode
  import keypad_pkg::*;
(
  input  logic [3:0] kpc,
  input  logic [3:0] kpr,
  output logic       raw_ok,
  output logic [3:0] raw_code
);

  logic [1:0] col;
  logic [1:0] row;

  always_comb begin
    col      = cold_index(kpc);
    row      = cold_index(kpr);
    raw_ok   = is_one_cold(kpc) && is_one_cold(kpr);
    raw_code = 4'd0;
    case (row)
      2'd0: begin
        case (col)
          2'd0:    raw_code = 4'd1;
          2'd1:    raw_code = 4'd2;
          2'd2:    raw_code = 4'd3;
          default: raw_code = KEY_A;
        endcase
      end
      2'd1: begin
        case (col)
          2'd0:    raw_code = 4'd4;
          2'd1:    raw_code = 4'd5;
          2'd2:    raw_code = 4'd6;
          default: raw_code = KEY_B;
        endcase
      end
      2'd2: begin
        case (col)
          2'd0:    raw_code = 4'd7;
          2'd1:    raw_code = 4'd8;
          2'd2:    raw_code = 4'd9;
          default: raw_code = KEY_C;
        endcase
      end
      default: begin
        case (col)
          2'd0:    raw_code = KEY_STAR;
          2'd1:    raw_code = 4'd0;
          2'd2:    raw_code = KEY_HASH;
          default: raw_code = KEY_D;
        endcase
      end
    endcase
  end

endmodule

// File: rtl/keypad_debounce.sv
// rtl/keypad_debounce.sv - press/release debouncer emitting one pulse per key press
// Purpose: debounce a decoded key press and its release; report the key code.
// Ports:
//   clk       in        system clock, rising edge
//   reset     in        synchronous, active-high
//   kpc       in  [3:0] column drive from the scanner, active-low one-hot
//   kpr       in  [3:0] row sense, active-low
//   key_code  out [3:0] last accepted key, held until the next accept
//   key_valid out       one-cycle pulse on each accepted press
//   key_held  out       high from acceptance until the release is debounced
module keypad_debounce
  import keypad_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 50000
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [3:0] kpc,
  input  logic [3:0] kpr,
  output logic [3:0] key_code,
  output logic       key_valid,
  output logic       key_held
);

  localparam int              CW   = $clog2(DEBOUNCE_CYCLES);
  localparam logic [CW-1:0]   TERM = CW'(DEBOUNCE_CYCLES - 1);

  logic       raw_ok;
  logic [3:0] raw_code;

  kd_state_t     state_q,     state_d;
  logic [CW-1:0] cnt_q,       cnt_d;
  logic [3:0]    cand_q,      cand_d;
  logic [3:0]    key_code_q,  key_code_d;
  logic          key_valid_q, key_valid_d;
  logic          key_held_q,  key_held_d;

  keypad_decode u_decode (
    .kpc      (kpc),
    .kpr      (kpr),
    .raw_ok   (raw_ok),
    .raw_code (raw_code)
  );

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    cand_d      = cand_q;
    key_code_d  = key_code_q;
    key_valid_d = 1'b0;
    key_held_d  = key_held_q;

    case (state_q)
      IDLE: begin
        key_held_d = 1'b0;
        if (raw_ok) begin
          cand_d  = raw_code;
          cnt_d   = '0;
          state_d = PRESS_WAIT;
        end
      end

      PRESS_WAIT: begin
        // Any glitch or a different key restarts from IDLE; the new key is
        // captured on the following sample, not this one.
        if (!raw_ok || (raw_code != cand_q)) begin
          state_d = IDLE;
        end else if (cnt_q == TERM) begin
          state_d     = HELD;
          key_code_d  = cand_q;
          key_valid_d = 1'b1;
          key_held_d  = 1'b1;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end

      HELD: begin
        key_held_d = 1'b1;
        // Only an all-high row sense counts as released; other keys are ignored.
        if (kpr == ROWS_NONE) begin
          cnt_d   = '0;
          state_d = RELEASE_WAIT;
        end
      end

      RELEASE_WAIT: begin
        if (kpr != ROWS_NONE) begin
          state_d = HELD;
        end else if (cnt_q == TERM) begin
          state_d    = IDLE;
          key_held_d = 1'b0;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      cand_q      <= 4'd0;
      key_code_q  <= 4'd0;
      key_valid_q <= 1'b0;
      key_held_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      cand_q      <= cand_d;
      key_code_q  <= key_code_d;
      key_valid_q <= key_valid_d;
      key_held_q  <= key_held_d;
    end
  end

  assign key_code  = key_code_q;
  assign key_valid = key_valid_q;
  assign key_held  = key_held_q;

endmodule

// File: tb/tb_keypad_debounce.sv
// tb/tb_keypad_debounce.sv - self-checking bench for keypad_debounce
module tb_keypad_debounce;

  localparam int N = 4;

  logic       clk = 1'b0;
  logic       reset;
  logic [3:0] kpc;
  logic [3:0] kpr;
  logic [3:0] key_code;
  logic       key_valid;
  logic       key_held;

  always #5 clk = ~clk;

  keypad_debounce #(.DEBOUNCE_CYCLES(N)) dut (
    .clk       (clk),
    .reset     (reset),
    .kpc       (kpc),
    .kpr       (kpr),
    .key_code  (key_code),
    .key_valid (key_valid),
    .key_held  (key_held)
  );

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;
  logic check_en = 1'b0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Behavioural model: run lengths of identical valid samples and of idle rows.
  int key_table [4][4] = '{'{1, 2, 3, 10}, '{4, 5, 6, 11}, '{7, 8, 9, 12}, '{14, 0, 15, 13}};

  function automatic int cold_pos(input logic [3:0] v);
    int pos   = -1;
    int zeros = 0;
    for (int i = 0; i < 4; i++) begin
      if (!v[3-i]) begin
        zeros++;
        pos = i;
      end
    end
    return (zeros == 1) ? pos : -1;
  endfunction

  logic [3:0] m_code  = 4'd0;
  logic       m_valid = 1'b0;
  logic       m_held  = 1'b0;
  logic [3:0] m_cand  = 4'd0;
  int         run     = 0;
  int         rrun    = 0;

  always @(posedge clk) begin
    int r;
    int c;
    r = cold_pos(kpr);
    c = cold_pos(kpc);
    m_valid = 1'b0;
    if (reset) begin
      m_code = 4'd0;
      m_held = 1'b0;
      run    = 0;
      rrun   = 0;
    end else if (!m_held) begin
      if (r >= 0 && c >= 0 && (run == 0 || 4'(key_table[r][c]) == m_cand)) begin
        if (run == 0) m_cand = 4'(key_table[r][c]);
        run++;
        if (run == N + 1) begin
          m_held  = 1'b1;
          m_valid = 1'b1;
          m_code  = m_cand;
          run     = 0;
          rrun    = 0;
        end
      end else begin
        run = 0;
      end
    end else begin
      if (kpr == 4'b1111) begin
        rrun++;
        if (rrun == N + 1) begin
          m_held = 1'b0;
          rrun   = 0;
          run    = 0;
        end
      end else begin
        rrun = 0;
      end
    end
  end

  always @(negedge clk) begin
    if (check_en) begin
      check("model_key_code",  32'(key_code),  32'(m_code));
      check("model_key_valid", 32'(key_valid), 32'(m_valid));
      check("model_key_held",  32'(key_held),  32'(m_held));
    end
  end

  // Event recorder for literal timing expectations.
  int   pulse_cnt      = 0;
  int   last_pulse_cyc = -1;
  int   last_fall_cyc  = -1;
  logic held_prev      = 1'b0;

  always @(negedge clk) begin
    if (key_valid === 1'b1) begin
      pulse_cnt++;
      last_pulse_cyc = cyc;
    end
    if (held_prev && key_held === 1'b0) last_fall_cyc = cyc;
    held_prev = (key_held === 1'b1);
  end

  task automatic drive(input logic [3:0] c, input logic [3:0] r, input int n);
    kpc = c;
    kpr = r;
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic press_expect(input logic [3:0] c, input logic [3:0] r, input int exp, input string name);
    int c0;
    c0 = cyc;
    drive(c, r, N + 2);
    check(name, 32'(key_code), 32'(exp));
    check({name, "_pulse_cyc"}, 32'(last_pulse_cyc), 32'(c0 + N + 1));
    drive(c, 4'b1111, N + 2);
  endtask

  int sweep_exp [16] = '{1, 2, 3, 10, 4, 5, 6, 11, 7, 8, 9, 12, 14, 0, 15, 13};

  initial begin
    int c0;
    int p0;
    logic [3:0] kc;
    logic [3:0] kr;

    // Reset with key '1' down.
    reset = 1'b1;
    kpc   = 4'b0111;
    kpr   = 4'b0111;
    @(posedge clk);
    #1;
    check_en = 1'b1;
    @(posedge clk);
    #1;
    check("rst_key_code",  32'(key_code),  32'd0);
    check("rst_key_valid", 32'(key_valid), 32'd0);
    check("rst_key_held",  32'(key_held),  32'd0);
    reset = 1'b0;
    c0 = cyc;
    drive(4'b0111, 4'b0111, 1);
    check("post_rst_key_code",  32'(key_code),  32'd0);
    check("post_rst_key_valid", 32'(key_valid), 32'd0);
    check("post_rst_key_held",  32'(key_held),  32'd0);
    drive(4'b0111, 4'b0111, 5);
    check("post_rst_pulse_cyc", 32'(last_pulse_cyc), 32'(c0 + 5));
    check("post_rst_code", 32'(key_code), 32'd1);
    drive(4'b0111, 4'b1111, 6);

    // Clean press of '5'.
    p0 = pulse_cnt;
    c0 = cyc;
    drive(4'b1011, 4'b1011, 12);
    check("clean5_pulses",    32'(pulse_cnt - p0), 32'd1);
    check("clean5_pulse_cyc", 32'(last_pulse_cyc), 32'(c0 + 5));
    check("clean5_code",      32'(key_code),       32'd5);
    check("clean5_held",      32'(key_held),       32'd1);
    c0 = cyc;
    drive(4'b1011, 4'b1111, 8);
    check("clean5_fall_cyc",  32'(last_fall_cyc),  32'(c0 + 5));
    check("clean5_released",  32'(key_held),       32'd0);

    // Bouncy press of '9'.
    p0 = pulse_cnt;
    for (int i = 0; i < 5; i++) drive(4'b1101, (i % 2 == 1) ? 4'b1101 : 4'b1111, 2);
    check("bounce9_no_pulse", 32'(pulse_cnt - p0), 32'd0);
    c0 = cyc;
    drive(4'b1101, 4'b1101, 8);
    check("bounce9_pulses",    32'(pulse_cnt - p0), 32'd1);
    check("bounce9_pulse_cyc", 32'(last_pulse_cyc), 32'(c0 + 5));
    check("bounce9_code",      32'(key_code),       32'd9);

    // Release bounce while held.
    p0 = pulse_cnt;
    drive(4'b1101, 4'b1111, 2);
    drive(4'b1101, 4'b1101, 1);
    check("relbounce_still_held", 32'(key_held), 32'd1);
    c0 = cyc;
    drive(4'b1101, 4'b1111, 6);
    check("relbounce_no_pulse", 32'(pulse_cnt - p0), 32'd0);
    check("relbounce_fall_cyc", 32'(last_fall_cyc),  32'(c0 + 5));
    check("relbounce_released", 32'(key_held),       32'd0);

    // Two keys in column 0.
    p0 = pulse_cnt;
    drive(4'b0111, 4'b0011, 20);
    check("twokey_no_pulse", 32'(pulse_cnt - p0), 32'd0);
    check("twokey_code",     32'(key_code),       32'd9);
    drive(4'b1111, 4'b1111, 2);

    // Mapping sweep.
    for (int c = 0; c < 4; c++) begin
      for (int r = 0; r < 4; r++) begin
        kc = 4'b1000 >> c;
        kr = 4'b1000 >> r;
        kc = ~kc;
        kr = ~kr;
        p0 = pulse_cnt;
        drive(kc, kr, N + 2);
        check($sformatf("sweep_code_r%0d_c%0d", r, c), 32'(key_code), 32'(sweep_exp[r*4+c]));
        check($sformatf("sweep_pulse_r%0d_c%0d", r, c), 32'(pulse_cnt - p0), 32'd1);
        drive(kc, 4'b1111, N + 2);
      end
    end
    press_expect(4'b0111, 4'b0111, 1,  "map_1");
    press_expect(4'b1101, 4'b1110, 15, "map_hash");
    press_expect(4'b1110, 4'b1110, 13, "map_d");

    // Reset in the middle of a press debounce.
    p0 = pulse_cnt;
    drive(4'b0111, 4'b1101, 3);
    reset = 1'b1;
    drive(4'b0111, 4'b1101, 2);
    check("midrst_code",     32'(key_code),       32'd0);
    check("midrst_no_pulse", 32'(pulse_cnt - p0), 32'd0);
    reset = 1'b0;
    c0 = cyc;
    drive(4'b0111, 4'b1101, 3);
    check("midrst_early_no_pulse", 32'(pulse_cnt - p0), 32'd0);
    drive(4'b0111, 4'b1101, 3);
    check("midrst_pulses",    32'(pulse_cnt - p0), 32'd1);
    check("midrst_pulse_cyc", 32'(last_pulse_cyc), 32'(c0 + 5));
    check("midrst_key_code",  32'(key_code),       32'd7);
    drive(4'b0111, 4'b1111, 6);

    check_en = 1'b0;
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
